pma_comma_aligner: RTL and testbench
====================================

// Module: pma_comma_aligner
// PURPOSE
// - Receive-side PMA code-group aligner for the 1000BASE-X ten-bit path; sits downstream of the EWRAP receive mux.
// - Consumes the serial bit stream, one bit per clk, searches for the 7-bit comma, and fixes the 10-bit boundary.
// - Delivers aligned 10-bit code-groups with a valid strobe to the PCS receive/sync logic.
// PARAMETERS
// - CONFIRM_COMMAS  2           same-phase commas required (incl. the first) to enter LOCKED; legal 1..15
// - COMMA_P         7'b0011111  comma pattern, bits a..g (K28.x RD-)
// - COMMA_N         7'b1100000  comma pattern, bits a..g (K28.x RD+)
// PORTS
// - clk            in   1   single clock; s_in sampled on rising edge
// - reset          in   1   synchronous, active-high
// - s_in           in   1   serial receive bit, first-transmitted bit (a) first
// - EN_CDET        in   1   comma-detect enable; 0 = hold current phase
// - rx_code_group  out  10  aligned code-group {a,b,c,d,e,i,f,g,h,j}, a at bit 9
// - rx_valid       out  1   one-cycle pulse: rx_code_group updated this cycle
// - comma_det      out  1   one-cycle pulse, with rx_valid, when the delivered group holds a comma
// - aligned        out  1   1 only in LOCKED
// - realign_cnt    out  8   saturating count (stops at 255) of phase changes made in CONFIRM/LOCKED
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is synchronous and active-high.
// - Shift: sr <= {sr[8:0], s_in} every clk. Define sr_n = {sr[8:0], s_in}.
// - Match: match = (sr_n[9:3]==COMMA_P || sr_n[9:3]==COMMA_N) && fill_done.
// - fill_done: set after 10 bits have been shifted in since reset, so no match on partly filled sr.
// - Phase counter ph, 0..9: an on-phase boundary is ph==9. ph wraps 9->0; it is forced to 0 on any accepted realign.
// - Group boundary: at the edge where ph==9 or a match is accepted, rx_code_group <= sr_n and rx_valid <= 1.
// - comma_det is 1 in that same cycle when match is true.
// - Latency: last bit (j) sampled at edge N -> group and rx_valid visible in cycle N (registered at edge N).
// - rx_valid spacing: exactly 10 clks while phase is stable; a realign may give a shorter interval, never 0.
// - States:
//   - HUNT: no rx_valid. A match (regardless of EN_CDET) -> CONFIRM with cnt=1, ph=0, group delivered.
//   - CONFIRM: an on-phase match -> cnt++; reaching cnt==CONFIRM_COMMAS -> LOCKED.
//     An off-phase match with EN_CDET=1 -> realign (ph=0, cnt=1, realign_cnt++, group delivered), stay CONFIRM.
//     An off-phase match with EN_CDET=0 is ignored.
//   - LOCKED: an off-phase match with EN_CDET=1 -> realign, -> CONFIRM with cnt=1, realign_cnt++.
//     An off-phase match with EN_CDET=0 is ignored; on-phase commas keep LOCKED.
// - CONFIRM_COMMAS==1: the first match in HUNT goes directly to LOCKED.
// - Simultaneous on-phase boundary and match: a single delivery with comma_det=1; this is not a realign.
// - Reset (also mid-stream): sr=0, ph=0, fill_done=0, state=HUNT, cnt=0.
//   Outputs after reset: rx_code_group=0, rx_valid=0, comma_det=0, aligned=0, realign_cnt=0.
// - Non-comma data never changes phase; the block does no running-disparity or code-group validity checking.
// TESTING
// - T1 Reset: hold reset 3 clks with random s_in -> all outputs 0, no rx_valid.
// - T2 Acquire: stream 3 junk bits, then K28.5- 0011111010 and D21.5 1010101010 repeated.
//   -> first rx_valid = 0011111010 with comma_det=1, then every 10 clks.
//   -> aligned=1 when the 2nd comma is delivered; D21.5 groups delivered intact.
// - T3 Realign: while LOCKED with EN_CDET=1, slip the stream by 4 bits.
//   -> next comma delivered off-phase, aligned=0, realign_cnt=1, re-LOCKED after the following comma.
// - T4 EN_CDET=0: repeat the T3 slip -> no realign, realign_cnt unchanged, aligned stays 1.
//   -> groups delivered on the old phase (misaligned data).
// - T5 Partial fill: after reset, send 1100000 as the first 7 bits -> no match until 10 bits have been received.
// - T6 Mid-stream reset while LOCKED: assert reset 1 clk -> aligned=0, HUNT.
//   -> reacquires on the next K28.5+ 1100000101 delivered with comma_det=1.

Source files
------------

// File: rtl/pma_comma_aligner.sv
// pma_comma_aligner
// Receive-side code-group aligner for the 1000BASE-X ten-bit path. The
// serial bit stream arrives one bit per clk. The block looks for the 7-bit
// comma (K28.x, either running disparity) and uses it to fix the 10-bit
// code-group boundary. It then delivers aligned code-groups with a valid
// strobe to the PCS receive/sync logic.
//
// Ports
//   clk            in   1   single clock, s_in sampled on the rising edge
//   reset          in   1   synchronous, active-high
//   s_in           in   1   serial receive bit, bit a first
//   EN_CDET        in   1   comma-detect enable, 0 = hold current phase
//   rx_code_group  out  10  aligned group {a,b,c,d,e,i,f,g,h,j}, a at bit 9
//   rx_valid       out  1   one-cycle pulse, rx_code_group updated
//   comma_det      out  1   one-cycle pulse with rx_valid, group holds a comma
//   aligned        out  1   high only while LOCKED
//   realign_cnt    out  8   saturating count of phase changes in CONFIRM/LOCKED
module pma_comma_aligner #(
    parameter int unsigned CONFIRM_COMMAS = 32'd2,
    parameter logic [6:0]  COMMA_P        = 7'b0011111,
    parameter logic [6:0]  COMMA_N        = 7'b1100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_in,
    input  logic       EN_CDET,
    output logic [9:0] rx_code_group,
    output logic       rx_valid,
    output logic       comma_det,
    output logic       aligned,
    output logic [7:0] realign_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] CONFIRM_W = CONFIRM_COMMAS[3:0];

    // True when a 7-bit window equals either comma polarity.
    function automatic logic is_comma(input logic [6:0] w);
        return (w == COMMA_P) || (w == COMMA_N);
    endfunction

    logic [9:0] sr_r;
    logic [9:0] sr_n_s;
    logic [3:0] fill_cnt_r;
    logic       fill_done_s;
    logic       match_s;
    logic [3:0] ph_r;
    logic [3:0] ph_nxt_s;
    logic       on_phase_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    state_t     state_r;
    state_t     state_nxt_s;
    logic       accept_s;
    logic       realign_s;
    logic       deliver_s;
    logic       comma_s;
    logic       aligned_nxt_s;
    logic [7:0] realign_cnt_nxt_s;

    // The window includes the bit arriving at this edge. The newest bit is
    // j, and the comma occupies the a..g positions at the top.
    assign sr_n_s = {sr_r[8:0], s_in};

    // sr_n holds ten real bits once nine have been stored before this edge.
    // This keeps reset zeros from forming a false comma.
    assign fill_done_s = (fill_cnt_r == 4'd9);
    assign match_s     = fill_done_s && is_comma(sr_n_s[9:3]);
    assign on_phase_s  = (ph_r == 4'd9);

    // Shift register and fill counter. The counter saturates at 9.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r       <= 10'd0;
            fill_cnt_r <= 4'd0;
        end else begin
            sr_r <= sr_n_s;
            if (!fill_done_s) begin
                fill_cnt_r <= fill_cnt_r + 4'd1;
            end
        end
    end

    // State register with the comma-confirm counter and the phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_HUNT;
            cnt_r   <= 4'd0;
            ph_r    <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ph_r    <= ph_nxt_s;
        end
    end

    // Next-state logic. accept_s marks a comma that sets the group phase.
    // An on-phase comma in LOCKED is not flagged because it changes nothing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        realign_s   = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (match_s) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = 4'd1;
                    state_nxt_s = (CONFIRM_W <= 4'd1) ? ST_LOCKED : ST_CONFIRM;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_CONFIRM: begin
                if (match_s && on_phase_s) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = cnt_r + 4'd1;
                    if ((cnt_r + 4'd1) >= CONFIRM_W) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_CONFIRM;
                    end
                end else if (match_s && EN_CDET) begin
                    accept_s    = 1'b1;
                    realign_s   = 1'b1;
                    cnt_nxt_s   = 4'd1;
                    state_nxt_s = (CONFIRM_W <= 4'd1) ? ST_LOCKED : ST_CONFIRM;
                end else begin
                    state_nxt_s = ST_CONFIRM;
                end
            end
            ST_LOCKED: begin
                if (match_s && !on_phase_s && EN_CDET) begin
                    accept_s    = 1'b1;
                    realign_s   = 1'b1;
                    cnt_nxt_s   = 4'd1;
                    state_nxt_s = (CONFIRM_W <= 4'd1) ? ST_LOCKED : ST_CONFIRM;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Output decode. Phase boundaries produce a group only after the first
    // comma. An on-phase comma is one delivery, not a realign.
    always_comb begin
        deliver_s         = accept_s || (on_phase_s && (state_r != ST_HUNT));
        comma_s           = deliver_s && match_s;
        aligned_nxt_s     = (state_nxt_s == ST_LOCKED);
        realign_cnt_nxt_s = realign_cnt;
        if (realign_s && (realign_cnt != 8'd255)) begin
            realign_cnt_nxt_s = realign_cnt + 8'd1;
        end else begin
            realign_cnt_nxt_s = realign_cnt;
        end
        if (accept_s || on_phase_s) begin
            ph_nxt_s = 4'd0;
        end else begin
            ph_nxt_s = ph_r + 4'd1;
        end
    end

    // Registered outputs. The code-group holds its value between deliveries.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_code_group <= 10'd0;
            rx_valid      <= 1'b0;
            comma_det     <= 1'b0;
            aligned       <= 1'b0;
            realign_cnt   <= 8'd0;
        end else begin
            if (deliver_s) begin
                rx_code_group <= sr_n_s;
            end
            rx_valid    <= deliver_s;
            comma_det   <= comma_s;
            aligned     <= aligned_nxt_s;
            realign_cnt <= realign_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_pma_comma_aligner.sv
// tb_pma_comma_aligner
// Self-checking bench for pma_comma_aligner. A bit-level reference model
// predicts every output on every clock. It tracks phase as the distance
// from the last accepted comma, modulo 10. Table vectors and short
// hand-written sequences add fixed expectations for acquisition, realign,
// EN_CDET hold, partial fill, mid-stream reset and counter saturation.
module tb_pma_comma_aligner;

    localparam int C = 2;
    localparam logic [9:0] K28P5_N = 10'b0011111010;
    localparam logic [9:0] K28P5_P = 10'b1100000101;
    localparam logic [9:0] D21P5   = 10'b1010101010;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_in;
    logic       en_cdet;
    logic [9:0] rx_code_group;
    logic       rx_valid;
    logic       comma_det;
    logic       aligned;
    logic [7:0] realign_cnt;

    pma_comma_aligner dut (
        .clk           (clk),
        .reset         (reset),
        .s_in          (s_in),
        .EN_CDET       (en_cdet),
        .rx_code_group (rx_code_group),
        .rx_valid      (rx_valid),
        .comma_det     (comma_det),
        .aligned       (aligned),
        .realign_cnt   (realign_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: phase is the distance from the last accepted comma.
    int m_cyc    = 0;
    int m_bits   = 0;
    int m_win    = 0;
    int m_anchor = 0;
    int m_mode   = 0;   // 0 hunt, 1 confirm, 2 locked
    int m_cnt    = 0;
    int m_rcnt   = 0;
    int m_group  = 0;
    int m_valid  = 0;
    int m_cdet   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic b, input logic e);
        int  top;
        bit  m;
        bit  onb;
        bit  dlv;
        m_cyc++;
        if (r) begin
            m_bits = 0; m_win = 0; m_mode = 0; m_cnt = 0; m_rcnt = 0;
            m_group = 0; m_valid = 0; m_cdet = 0;
        end else begin
            m_bits++;
            m_win = (m_win * 2 + int'(b)) % 1024;
            top   = m_win / 8;
            m     = (m_bits >= 10) && (top == 'h1F || top == 'h60);
            onb   = (m_mode != 0) && ((m_cyc - m_anchor) % 10 == 0);
            dlv   = 1'b0;
            if (m_mode == 0) begin
                if (m) begin
                    dlv = 1'b1; m_anchor = m_cyc; m_cnt = 1; m_mode = (C == 1) ? 2 : 1;
                end
            end else if (onb) begin
                dlv = 1'b1;
                if (m && m_mode == 1) begin
                    m_cnt++;
                    if (m_cnt >= C) m_mode = 2;
                end
            end else if (m && e) begin
                dlv = 1'b1; m_anchor = m_cyc; m_cnt = 1; m_mode = (C == 1) ? 2 : 1;
                if (m_rcnt < 255) m_rcnt++;
            end
            m_valid = int'(dlv);
            m_cdet  = int'(dlv && m);
            if (dlv) m_group = m_win;
        end
    endtask

    task automatic step(input logic r, input logic b, input logic e);
        reset = r; s_in = b; en_cdet = e;
        @(posedge clk);
        model_step(r, b, e);
        #1;
        chk("model.rx_valid",      32'(rx_valid),      32'(m_valid));
        chk("model.comma_det",     32'(comma_det),     32'(m_cdet));
        chk("model.rx_code_group", 32'(rx_code_group), 32'(m_group));
        chk("model.aligned",       32'(aligned),       32'(m_mode == 2));
        chk("model.realign_cnt",   32'(realign_cnt),   32'(m_rcnt));
    endtask

    task automatic send(input logic [9:0] g, input int n, input logic e);
        for (int k = n - 1; k >= 0; k--) step(1'b0, g[k], e);
    endtask

    typedef struct {
        int         nbits;
        logic [9:0] bits;
        logic       en;
        logic       exp_valid;
        logic [9:0] exp_group;
        logic       exp_cdet;
        logic       exp_aligned;
        logic [7:0] exp_rcnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] g;
        logic       rb;
        int         sel;
        logic       e;

        // Acquire, realign on a 4-bit slip, then the same slip with EN_CDET=0.
        tbl[0]  = '{3,  10'b0000000101, 1'b1, 1'b0, 10'd0,         1'b0, 1'b0, 8'd0};
        tbl[1]  = '{10, K28P5_N,        1'b1, 1'b1, K28P5_N,       1'b1, 1'b0, 8'd0};
        tbl[2]  = '{10, D21P5,          1'b1, 1'b1, D21P5,         1'b0, 1'b0, 8'd0};
        tbl[3]  = '{10, K28P5_N,        1'b1, 1'b1, K28P5_N,       1'b1, 1'b1, 8'd0};
        tbl[4]  = '{10, D21P5,          1'b1, 1'b1, D21P5,         1'b0, 1'b1, 8'd0};
        tbl[5]  = '{10, K28P5_N,        1'b1, 1'b1, K28P5_N,       1'b1, 1'b1, 8'd0};
        tbl[6]  = '{4,  10'b0000001010, 1'b1, 1'b0, K28P5_N,       1'b0, 1'b1, 8'd0};
        tbl[7]  = '{10, D21P5,          1'b1, 1'b0, 10'b1010101010, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{10, K28P5_N,        1'b1, 1'b1, K28P5_N,       1'b1, 1'b0, 8'd1};
        tbl[9]  = '{10, D21P5,          1'b1, 1'b1, D21P5,         1'b0, 1'b0, 8'd1};
        tbl[10] = '{10, K28P5_N,        1'b1, 1'b1, K28P5_N,       1'b1, 1'b1, 8'd1};
        tbl[11] = '{4,  10'b0000001010, 1'b0, 1'b0, K28P5_N,       1'b0, 1'b1, 8'd1};
        tbl[12] = '{10, D21P5,          1'b0, 1'b0, 10'b1010101010, 1'b0, 1'b1, 8'd1};
        tbl[13] = '{10, K28P5_N,        1'b0, 1'b0, 10'b1010001111, 1'b0, 1'b1, 8'd1};
        tbl[14] = '{10, D21P5,          1'b0, 1'b0, 10'b1010101010, 1'b0, 1'b1, 8'd1};

        reset = 1'b1; s_in = 1'b0; en_cdet = 1'b1;

        // Reset held for three clocks with random serial data.
        for (int i = 0; i < 3; i++) begin
            rb = 1'(($urandom() % 2));
            step(1'b1, rb, 1'b1);
            chk("reset.rx_valid",      32'(rx_valid),      32'd0);
            chk("reset.rx_code_group", 32'(rx_code_group), 32'd0);
            chk("reset.comma_det",     32'(comma_det),     32'd0);
            chk("reset.aligned",       32'(aligned),       32'd0);
            chk("reset.realign_cnt",   32'(realign_cnt),   32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            send(tbl[i].bits, tbl[i].nbits, tbl[i].en);
            chk($sformatf("vec%0d.rx_valid", i),      32'(rx_valid),      32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d.rx_code_group", i), 32'(rx_code_group), 32'(tbl[i].exp_group));
            chk($sformatf("vec%0d.comma_det", i),     32'(comma_det),     32'(tbl[i].exp_cdet));
            chk($sformatf("vec%0d.aligned", i),       32'(aligned),       32'(tbl[i].exp_aligned));
            chk($sformatf("vec%0d.realign_cnt", i),   32'(realign_cnt),   32'(tbl[i].exp_rcnt));
        end

        // Mid-stream reset while locked, then reacquire on K28.5+.
        step(1'b1, 1'b1, 1'b1);
        chk("midreset.aligned",     32'(aligned),       32'd0);
        chk("midreset.rx_valid",    32'(rx_valid),      32'd0);
        chk("midreset.group",       32'(rx_code_group), 32'd0);
        chk("midreset.realign_cnt", 32'(realign_cnt),   32'd0);
        send(10'b0000010101, 5, 1'b1);
        send(K28P5_P, 10, 1'b1);
        chk("reacq.rx_valid",  32'(rx_valid),      32'd1);
        chk("reacq.group",     32'(rx_code_group), 32'(K28P5_P));
        chk("reacq.comma_det", 32'(comma_det),     32'd1);
        chk("reacq.aligned",   32'(aligned),       32'd0);

        // Partial fill: a comma-shaped start must not match early.
        step(1'b1, 1'b0, 1'b1);
        g = 10'b1100000011;
        for (int k = 9; k >= 1; k--) begin
            step(1'b0, g[k], 1'b1);
            chk("fill_n.rx_valid", 32'(rx_valid), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        g = 10'b1111101011;
        for (int k = 9; k >= 0; k--) begin
            step(1'b0, g[k], 1'b1);
            chk("fill_p.rx_valid", 32'(rx_valid), 32'd0);
        end

        // Repeated one-bit slips drive realign_cnt into saturation.
        step(1'b1, 1'b0, 1'b1);
        send(10'b0000010101, 5, 1'b1);
        send(K28P5_N, 10, 1'b1);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 1'b1);
            send(K28P5_N, 10, 1'b1);
        end
        chk("sat.realign_cnt", 32'(realign_cnt), 32'd255);
        chk("sat.comma_det",   32'(comma_det),   32'd1);
        chk("sat.aligned",     32'(aligned),     32'd0);

        // Random mix of commas, data, slips, EN_CDET changes and resets.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 350; i++) begin
            sel = $urandom_range(0, 9);
            e   = ($urandom_range(0, 3) != 0);
            case (sel)
                0, 1, 2: send(K28P5_N, 10, e);
                3, 4:    send(K28P5_P, 10, e);
                5, 6:    send(D21P5, 10, e);
                7: begin
                    g = 10'($urandom());
                    send(g, 10, e);
                end
                8: begin
                    g = 10'($urandom());
                    send(g, $urandom_range(1, 9), e);
                end
                default: begin
                    if ($urandom_range(0, 4) == 0) step(1'b1, 1'b0, e);
                    else send(D21P5, 10, e);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
